// File: rtl/rtc_sched_pkg.sv
// Shared types and constants for the RTC command scheduler.
// Command indices follow the pend bit order {inic,stop,hora,fecha,timer,leer}.
package rtc_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GUARD = 2'd2,
        S_WAIT  = 2'd3
    } state_e;

    localparam int NCMD = 6;

    localparam int CMD_INIC  = 5;
    localparam int CMD_STOP  = 4;
    localparam int CMD_HORA  = 3;
    localparam int CMD_FECHA = 2;
    localparam int CMD_TIMER = 1;
    localparam int CMD_LEER  = 0;

    typedef logic [NCMD-1:0] cmd_vec_t;

    localparam cmd_vec_t PEND_RST = 6'b100000;

    localparam int DEF_READ_PERIOD = 10_000_000;
    localparam int DEF_TIMEOUT_CYC = 65_535;
    localparam int DEF_CNT_W       = 24;

endpackage

// File: rtl/rtc_read_tick.sv
// Free-running period counter; tick is high for the single cycle
// in which the count sits at PERIOD-1, then the count wraps to 0.
module rtc_read_tick
    import rtc_sched_pkg::*;
#(
    parameter int PERIOD = DEF_READ_PERIOD,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_W'(PERIOD - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rtc_cmd_scheduler.sv
// Serialises user requests and periodic reads into the RTC engine,
// one strobe per transaction, with a guarded wait on the ready handshake.
module rtc_cmd_scheduler
    import rtc_sched_pkg::*;
#(
    parameter int READ_PERIOD = DEF_READ_PERIOD,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_hora,
    input  logic       req_fecha,
    input  logic       req_timer,
    input  logic       req_stop,
    input  logic       ready,
    output logic       leer,
    output logic       esc_hora,
    output logic       esc_fecha,
    output logic       esc_timer,
    output logic       stop_ring,
    output logic       inic,
    output logic       busy,
    output logic [5:0] pend,
    output logic       timeout_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_e          state_q, state_d;
    cmd_vec_t        pend_q, pend_d;
    cmd_vec_t        cmd_q, cmd_d;
    cmd_vec_t        set_v, clr_v, pick, strb;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            terr_q, terr_d;
    logic            tick;

    rtc_read_tick #(
        .PERIOD (READ_PERIOD),
        .CNT_W  (CNT_W)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign set_v = {1'b0, req_stop, req_hora, req_fecha, req_timer, tick};

    always_comb begin
        pick = '0;
        priority case (1'b1)
            pend_q[CMD_INIC]:  pick[CMD_INIC]  = 1'b1;
            pend_q[CMD_STOP]:  pick[CMD_STOP]  = 1'b1;
            pend_q[CMD_HORA]:  pick[CMD_HORA]  = 1'b1;
            pend_q[CMD_FECHA]: pick[CMD_FECHA] = 1'b1;
            pend_q[CMD_TIMER]: pick[CMD_TIMER] = 1'b1;
            pend_q[CMD_LEER]:  pick[CMD_LEER]  = 1'b1;
            default:           pick            = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        tcnt_d  = tcnt_q;
        terr_d  = terr_q;
        clr_v   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (|pend_q) begin
                    cmd_d   = pick;
                    clr_v   = pick;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_GUARD;
            // ready still reflects the previous transaction here
            S_GUARD: begin
                tcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ready) begin
                    terr_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    terr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        // a set in the same cycle as the clear keeps the flag
        pend_d = (pend_q & ~clr_v) | set_v;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pend_q  <= PEND_RST;
            cmd_q   <= '0;
            tcnt_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cmd_q   <= cmd_d;
            tcnt_q  <= tcnt_d;
            terr_q  <= terr_d;
        end
    end

    assign strb = (state_q == S_ISSUE) ? cmd_q : '0;

    assign inic        = strb[CMD_INIC];
    assign stop_ring   = strb[CMD_STOP];
    assign esc_hora    = strb[CMD_HORA];
    assign esc_fecha   = strb[CMD_FECHA];
    assign esc_timer   = strb[CMD_TIMER];
    assign leer        = strb[CMD_LEER];
    assign busy        = (state_q != S_IDLE);
    assign pend        = pend_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_rtc_cmd_scheduler.sv
// Directed bench for rtc_cmd_scheduler with READ_PERIOD=20, TIMEOUT_CYC=50.
// Cycle numbers count negedges since reset release.
module tb_rtc_cmd_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_hora = 1'b0;
    logic       req_fecha = 1'b0;
    logic       req_timer = 1'b0;
    logic       req_stop = 1'b0;
    logic       ready = 1'b0;
    logic       leer, esc_hora, esc_fecha, esc_timer, stop_ring, inic;
    logic       busy, timeout_err;
    logic [5:0] pend;

    int         cyc = 0;
    int         vecs = 0;
    int         errs = 0;
    int         rmode = 0;
    int         rcnt = 0;
    int         n_fecha = 0;
    logic [5:0] sv;

    always #5 clk = ~clk;

    rtc_cmd_scheduler #(
        .READ_PERIOD (20),
        .TIMEOUT_CYC (50),
        .CNT_W       (24)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_hora    (req_hora),
        .req_fecha   (req_fecha),
        .req_timer   (req_timer),
        .req_stop    (req_stop),
        .ready       (ready),
        .leer        (leer),
        .esc_hora    (esc_hora),
        .esc_fecha   (esc_fecha),
        .esc_timer   (esc_timer),
        .stop_ring   (stop_ring),
        .inic        (inic),
        .busy        (busy),
        .pend        (pend),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
                   tag, cyc, obs, exp);
        end
    endtask

    // one cycle: drop request pulses, sample strobes, model the engine
    task automatic step();
        @(negedge clk);
        cyc++;
        req_hora  = 1'b0;
        req_fecha = 1'b0;
        req_timer = 1'b0;
        req_stop  = 1'b0;
        sv = {inic, stop_ring, esc_hora, esc_fecha, esc_timer, leer};
        chk("strobe_onehot", 32'($onehot0(sv)), 32'd1);
        if (sv[2]) n_fecha++;
        case (rmode)
            0: begin
                ready = 1'b0;
                if (rcnt > 0) begin
                    rcnt--;
                    if (rcnt == 0) ready = 1'b1;
                end
                if (sv != 6'b0) rcnt = 5;
            end
            1: begin
                ready = 1'b0;
                rcnt  = 0;
            end
            default: ready = 1'b1;
        endcase
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_strobes", {inic, stop_ring, esc_hora, esc_fecha,
                            esc_timer, leer}, 6'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pend", pend, 6'b100000);
        chk("rst_terr", timeout_err, 1'b0);

        @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        step();
        chk("inic_first", sv, 6'b100000);
        chk("busy_issue", busy, 1'b1);
        run_to(20);
        chk("pend_leer_tick", pend, 6'b000001);
        step();
        chk("leer_period", sv, 6'b000001);

        run_to(28);
        req_hora = 1'b1;
        req_timer = 1'b1;
        run_to(29);
        chk("pend_hora_timer", pend, 6'b001010);
        run_to(30);
        chk("esc_hora_first", sv, 6'b001000);
        run_to(31);
        chk("pend_timer_only", pend, 6'b000010);
        run_to(36);
        chk("idle_between", busy, 1'b0);
        run_to(37);
        chk("esc_timer_second", sv, 6'b000010);

        run_to(44);
        chk("leer_second", sv, 6'b000001);
        req_fecha = 1'b1;
        run_to(46);
        req_fecha = 1'b1;
        run_to(48);
        req_fecha = 1'b1;
        run_to(49);
        chk("pend_fecha_collapse", pend, 6'b000100);
        chk("busy_leer", busy, 1'b1);
        run_to(51);
        chk("esc_fecha", sv, 6'b000100);
        run_to(60);
        chk("fecha_once", n_fecha, 1);
        run_to(61);
        chk("leer_third", sv, 6'b000001);

        run_to(68);
        req_timer = 1'b1;
        rmode = 1;
        run_to(70);
        chk("esc_timer_to", sv, 6'b000010);
        run_to(121);
        chk("wait_last_busy", busy, 1'b1);
        chk("wait_last_terr", timeout_err, 1'b0);
        run_to(122);
        chk("to_idle", busy, 1'b0);
        chk("to_terr_set", timeout_err, 1'b1);
        chk("to_pend", pend, 6'b000001);
        rmode = 0;
        run_to(123);
        chk("leer_after_to", sv, 6'b000001);
        run_to(128);
        chk("terr_sticky", timeout_err, 1'b1);
        run_to(129);
        chk("terr_cleared", timeout_err, 1'b0);
        chk("idle_after_clr", busy, 1'b0);

        run_to(130);
        req_hora = 1'b1;
        run_to(132);
        chk("esc_hora_rst", sv, 6'b001000);
        run_to(135);
        chk("busy_wait_rst", busy, 1'b1);
        reset = 1'b0;
        #1;
        chk("arst_strobes", {inic, stop_ring, esc_hora, esc_fecha,
                             esc_timer, leer}, 6'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_pend", pend, 6'b100000);
        chk("arst_terr", timeout_err, 1'b0);
        rcnt = 0;
        repeat (3) step();
        reset = 1'b1;
        cyc = 0;
        rcnt = 0;
        ready = 1'b0;
        step();
        chk("inic_reissued", sv, 6'b100000);

        run_to(7);
        rmode = 2;
        run_to(8);
        req_stop = 1'b1;
        req_hora = 1'b1;
        req_fecha = 1'b1;
        req_timer = 1'b1;
        run_to(9);
        chk("pend_four", pend, 6'b011110);
        run_to(10);
        chk("stuck_stop", sv, 6'b010000);
        run_to(12);
        chk("stuck_gap", sv, 6'b000000);
        run_to(14);
        chk("stuck_hora", sv, 6'b001000);
        run_to(18);
        chk("stuck_fecha", sv, 6'b000100);
        run_to(22);
        chk("stuck_timer", sv, 6'b000010);
        run_to(26);
        chk("stuck_leer", sv, 6'b000001);
        run_to(30);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
